// File: rtl/rng_pkg.sv
// Shared types and constants for the random-number sequencer.
// Every rng_* file imports this package.
package rng_pkg;

    localparam int SAMPLE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WARMUP = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_FAIL   = 3'd4
    } state_t;

endpackage

// File: rtl/rng_ctrl_if.sv
// Valid/ready word channel from rng_ctrl to its consumer.
// rng_ctrl drives this channel through the master modport.
interface rng_ctrl_if
    import rng_pkg::*;
#(
    parameter int WORD_BYTES = 4
);
    localparam int WORD_W = SAMPLE_W * WORD_BYTES;

    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output word_out,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_out,
        input  word_valid,
        output word_ready
    );

endinterface

// File: rtl/rng_rep_test.sv
// Repetition-count health test. It counts identical consecutive captured bytes.
// It asserts trip in the capture cycle that brings the run length to REP_LIMIT.
module rng_rep_test
    import rng_pkg::*;
#(
    parameter int REP_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                capture,
    input  logic [SAMPLE_W-1:0] sample,
    output logic                trip
);

    localparam int REP_W = $clog2(REP_LIMIT + 1);

    logic [SAMPLE_W-1:0] last_reg;
    logic [REP_W-1:0]    rep_cnt_reg;
    logic [REP_W-1:0]    rep_cnt_next;

    // The run restarts at 1 on any change. The last value is kept across word boundaries.
    always_comb begin
        rep_cnt_next = REP_W'(1);
        if (sample == last_reg) begin
            rep_cnt_next = rep_cnt_reg + 1'b1;
        end
    end

    assign trip = capture && (rep_cnt_next == REP_W'(REP_LIMIT));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            last_reg    <= '0;
            rep_cnt_reg <= '0;
        end else if (capture) begin
            last_reg    <= sample;
            rep_cnt_reg <= rep_cnt_next;
        end
    end

endmodule

// File: rtl/rng_ctrl.sv
// Sequencer for rng_gen_8. It gates the generator, discards warm-up output and packs decimated samples.
// It also runs the repetition health test and delivers words over valid/ready.
module rng_ctrl
    import rng_pkg::*;
#(
    parameter int WARMUP_CYCLES = 16,
    parameter int SAMPLE_DIV    = 4,
    parameter int WORD_BYTES    = 4,
    parameter int REP_LIMIT     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                clr_fail,
    input  logic [SAMPLE_W-1:0] rng_data,
    output logic                rng_enable,
    output logic                busy,
    output logic                health_fail,
    rng_ctrl_if.master          word_if
);

    localparam int WORD_W = SAMPLE_W * WORD_BYTES;
    localparam int WARM_W = $clog2(WARMUP_CYCLES + 1);
    localparam int DIV_W  = $clog2(SAMPLE_DIV + 1);
    localparam int BYTE_W = $clog2(WORD_BYTES + 1);

    state_t              state_reg, state_next;
    logic [WARM_W-1:0]   warm_cnt_reg, warm_cnt_next;
    logic [DIV_W-1:0]    div_cnt_reg, div_cnt_next;
    logic [BYTE_W-1:0]   byte_cnt_reg, byte_cnt_next;
    logic [WORD_W-1:0]   word_sr_reg, word_sr_next;
    logic [WORD_W-1:0]   word_out_reg, word_out_next;
    logic                word_valid_reg, word_valid_next;
    logic                rng_enable_reg, rng_enable_next;
    logic                busy_reg, busy_next;
    logic                health_fail_reg, health_fail_next;
    logic [WORD_W-1:0]   sr_shifted;
    logic                capture;
    logic                rep_clear;
    logic                rep_trip;

    // Each byte lane takes its lower neighbour, so the first sample ends up in the MSB.
    generate
        for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            if (gi == 0) begin : g_first
                assign sr_shifted[SAMPLE_W-1:0] = rng_data;
            end else begin : g_shift
                assign sr_shifted[gi*SAMPLE_W +: SAMPLE_W] = word_sr_reg[(gi-1)*SAMPLE_W +: SAMPLE_W];
            end
        end
    endgenerate

    assign capture   = (state_reg == ST_SAMPLE) && (div_cnt_reg == DIV_W'(SAMPLE_DIV - 1));
    assign rep_clear = (state_reg == ST_IDLE) && req;

    rng_rep_test #(
        .REP_LIMIT (REP_LIMIT)
    ) u_rep_test (
        .clk     (clk),
        .rst     (rst),
        .clear   (rep_clear),
        .capture (capture),
        .sample  (rng_data),
        .trip    (rep_trip)
    );

    always_comb begin
        state_next    = state_reg;
        warm_cnt_next = warm_cnt_reg;
        div_cnt_next  = div_cnt_reg;
        byte_cnt_next = byte_cnt_reg;
        word_sr_next  = word_sr_reg;
        word_out_next = word_out_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    state_next    = ST_WARMUP;
                    warm_cnt_next = '0;
                end
            end
            ST_WARMUP: begin
                if (!req) begin
                    state_next = ST_IDLE;
                end else if (warm_cnt_reg == WARM_W'(WARMUP_CYCLES - 1)) begin
                    state_next    = ST_SAMPLE;
                    div_cnt_next  = '0;
                    byte_cnt_next = '0;
                end else begin
                    warm_cnt_next = warm_cnt_reg + 1'b1;
                end
            end
            ST_SAMPLE: begin
                // A health trip outranks both an abort and a completed word.
                if (rep_trip) begin
                    state_next = ST_FAIL;
                end else if (!req) begin
                    state_next = ST_IDLE;
                end else if (capture) begin
                    div_cnt_next = '0;
                    word_sr_next = sr_shifted;
                    if (byte_cnt_reg == BYTE_W'(WORD_BYTES - 1)) begin
                        state_next    = ST_HOLD;
                        word_out_next = sr_shifted;
                        byte_cnt_next = '0;
                    end else begin
                        byte_cnt_next = byte_cnt_reg + 1'b1;
                    end
                end else begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end
            end
            ST_HOLD: begin
                if (word_valid_reg && word_if.word_ready) begin
                    if (req) begin
                        state_next    = ST_SAMPLE;
                        div_cnt_next  = '0;
                        byte_cnt_next = '0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_FAIL: begin
                if (clr_fail) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Output registers are decoded from the next state so they line up with state_reg.
        rng_enable_next  = (state_next == ST_WARMUP) || (state_next == ST_SAMPLE) || (state_next == ST_HOLD);
        busy_next        = rng_enable_next;
        word_valid_next  = (state_next == ST_HOLD);
        health_fail_next = (state_next == ST_FAIL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            warm_cnt_reg    <= '0;
            div_cnt_reg     <= '0;
            byte_cnt_reg    <= '0;
            word_sr_reg     <= '0;
            word_out_reg    <= '0;
            word_valid_reg  <= 1'b0;
            rng_enable_reg  <= 1'b0;
            busy_reg        <= 1'b0;
            health_fail_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            warm_cnt_reg    <= warm_cnt_next;
            div_cnt_reg     <= div_cnt_next;
            byte_cnt_reg    <= byte_cnt_next;
            word_sr_reg     <= word_sr_next;
            word_out_reg    <= word_out_next;
            word_valid_reg  <= word_valid_next;
            rng_enable_reg  <= rng_enable_next;
            busy_reg        <= busy_next;
            health_fail_reg <= health_fail_next;
        end
    end

    assign word_if.word_out   = word_out_reg;
    assign word_if.word_valid = word_valid_reg;
    assign rng_enable         = rng_enable_reg;
    assign busy               = busy_reg;
    assign health_fail        = health_fail_reg;

endmodule

// File: tb/tb_rng_ctrl.sv
// Testbench for rng_ctrl with default parameters, using directed scenarios and a random-stream scoreboard.
// Cycle k is the period after the k-th rising edge following the req rise. Inputs are set and outputs read 1 ns into it.
module tb_rng_ctrl;
    localparam int W  = 16;
    localparam int D  = 4;
    localparam int WB = 4;
    localparam int RL = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic       clr_fail;
    logic [7:0] rng_data;
    logic       rng_enable;
    logic       busy;
    logic       health_fail;

    int n_tests = 0;
    int n_fail  = 0;
    int rel     = 0;
    int mode    = 0;   // 0: cycle number, 1: stuck 8'hA5, 2: random two-symbol source

    rng_ctrl_if #(.WORD_BYTES(WB)) wif ();

    rng_ctrl #(
        .WARMUP_CYCLES (W),
        .SAMPLE_DIV    (D),
        .WORD_BYTES    (WB),
        .REP_LIMIT     (RL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .clr_fail    (clr_fail),
        .rng_data    (rng_data),
        .rng_enable  (rng_enable),
        .busy        (busy),
        .health_fail (health_fail),
        .word_if     (wif)
    );

    always #5 clk = ~clk;

    task automatic drive_data();
        case (mode)
            0:       rng_data = 8'(rel);
            1:       rng_data = 8'hA5;
            default: rng_data = ($urandom_range(0, 1) != 0) ? 8'h3C : 8'h3D;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rel++;
        drive_data();
    endtask

    task automatic start_req();
        rel = 0;
        drive_data();
        req = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; clr_fail = 1'b0; wif.word_ready = 1'b0; mode = 0;
        rel = 0; drive_data();
        repeat (3) tick();
        n_tests++; if (rng_enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable got %b want 0", rng_enable); end
        n_tests++; if (wif.word_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", wif.word_valid); end
        n_tests++; if (wif.word_out !== 32'h0) begin n_fail++; $display("FAIL reset_word got %h want 0", wif.word_out); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (health_fail !== 1'b0) begin n_fail++; $display("FAIL reset_hfail got %b want 0", health_fail); end
        rst = 1'b0;
        tick();
        start_req();
        tick();
        n_tests++; if (rng_enable !== 1'b1) begin n_fail++; $display("FAIL latency_enable cycle %0d got %b want 1", rel, rng_enable); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL latency_busy cycle %0d got %b want 1", rel, busy); end
        while (rel < 1 + W + WB * D) begin
            n_tests++; if (wif.word_valid !== 1'b0) begin n_fail++; $display("FAIL early_valid cycle %0d got %b want 0", rel, wif.word_valid); end
            tick();
        end
        n_tests++; if (wif.word_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid cycle %0d got %b want 1", rel, wif.word_valid); end
        n_tests++; if (wif.word_out !== 32'h14181C20) begin n_fail++; $display("FAIL first_word got %h want 14181c20", wif.word_out); end
        $display("[TB] reset/latency: word %h valid at cycle %0d", wif.word_out, rel);
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        logic [31:0] exp_word;
        int h;
        held = 32'h14181C20;
        repeat (10) begin
            tick();
            n_tests++; if (wif.word_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cycle %0d got %b want 1", rel, wif.word_valid); end
            n_tests++; if (wif.word_out !== held) begin n_fail++; $display("FAIL bp_word cycle %0d got %h want %h", rel, wif.word_out, held); end
        end
        h = rel;
        wif.word_ready = 1'b1;
        tick();
        wif.word_ready = 1'b0;
        n_tests++; if (wif.word_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drop got %b want 0", wif.word_valid); end
        n_tests++; if (rng_enable !== 1'b1) begin n_fail++; $display("FAIL bp_enable got %b want 1", rng_enable); end
        while (rel < h + WB * D + 1) begin
            n_tests++; if (wif.word_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_early cycle %0d got %b want 0", rel, wif.word_valid); end
            tick();
        end
        exp_word = {8'(h + 4), 8'(h + 8), 8'(h + 12), 8'(h + 16)};
        n_tests++; if (wif.word_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid cycle %0d got %b want 1", rel, wif.word_valid); end
        n_tests++; if (wif.word_out !== exp_word) begin n_fail++; $display("FAIL b2b_word got %h want %h", wif.word_out, exp_word); end
        $display("[TB] back-to-back: handshake at %0d, word %h valid at cycle %0d", h, wif.word_out, rel);
    endtask

    task automatic test_req_low_hold();
        req = 1'b0;
        repeat (3) begin
            tick();
            n_tests++; if (wif.word_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid cycle %0d got %b want 1", rel, wif.word_valid); end
            n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hold_busy cycle %0d got %b want 1", rel, busy); end
        end
        wif.word_ready = 1'b1;
        tick();
        wif.word_ready = 1'b0;
        n_tests++; if (wif.word_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release_valid got %b want 0", wif.word_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_release_busy got %b want 0", busy); end
        n_tests++; if (rng_enable !== 1'b0) begin n_fail++; $display("FAIL hold_release_enable got %b want 0", rng_enable); end
        $display("[TB] req low in hold: word accepted, idle at cycle %0d", rel);
        repeat (2) tick();
    endtask

    task automatic test_stuck();
        mode = 1;
        start_req();
        while (rel < 1 + W + WB * D) begin
            n_tests++; if (health_fail !== 1'b0) begin n_fail++; $display("FAIL stuck_early_hfail cycle %0d got %b want 0", rel, health_fail); end
            tick();
        end
        n_tests++; if (health_fail !== 1'b1) begin n_fail++; $display("FAIL stuck_hfail cycle %0d got %b want 1", rel, health_fail); end
        n_tests++; if (rng_enable !== 1'b0) begin n_fail++; $display("FAIL stuck_enable got %b want 0", rng_enable); end
        n_tests++; if (wif.word_valid !== 1'b0) begin n_fail++; $display("FAIL stuck_valid got %b want 0", wif.word_valid); end
        repeat (4) begin
            tick();
            n_tests++; if (health_fail !== 1'b1) begin n_fail++; $display("FAIL stuck_sticky cycle %0d got %b want 1", rel, health_fail); end
            n_tests++; if (wif.word_valid !== 1'b0) begin n_fail++; $display("FAIL stuck_sticky_valid got %b want 0", wif.word_valid); end
        end
        req = 1'b0;
        clr_fail = 1'b1;
        tick();
        clr_fail = 1'b0;
        n_tests++; if (health_fail !== 1'b0) begin n_fail++; $display("FAIL clr_hfail got %b want 0", health_fail); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy got %b want 0", busy); end
        $display("[TB] stuck source: tripped and cleared at cycle %0d", rel);
        mode = 0;
        tick();
    endtask

    task automatic test_abort();
        start_req();
        while (rel < 25) tick();
        req = 1'b0;
        tick();
        n_tests++; if (rng_enable !== 1'b0) begin n_fail++; $display("FAIL abort_enable got %b want 0", rng_enable); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
        repeat (12) begin
            tick();
            n_tests++; if (wif.word_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid cycle %0d got %b want 0", rel, wif.word_valid); end
        end
        start_req();
        tick();
        while (rel < 1 + W + WB * D) begin
            n_tests++; if (wif.word_valid !== 1'b0) begin n_fail++; $display("FAIL restart_early cycle %0d got %b want 0", rel, wif.word_valid); end
            tick();
        end
        n_tests++; if (wif.word_valid !== 1'b1) begin n_fail++; $display("FAIL restart_valid got %b want 1", wif.word_valid); end
        n_tests++; if (wif.word_out !== 32'h14181C20) begin n_fail++; $display("FAIL restart_word got %h want 14181c20", wif.word_out); end
        $display("[TB] abort/restart: word %h valid at cycle %0d", wif.word_out, rel);
    endtask

    task automatic test_reset_in_hold();
        rst = 1'b1;
        tick();
        n_tests++; if (wif.word_valid !== 1'b0) begin n_fail++; $display("FAIL rsthold_valid got %b want 0", wif.word_valid); end
        n_tests++; if (wif.word_out !== 32'h0) begin n_fail++; $display("FAIL rsthold_word got %h want 0", wif.word_out); end
        n_tests++; if (rng_enable !== 1'b0) begin n_fail++; $display("FAIL rsthold_enable got %b want 0", rng_enable); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rsthold_busy got %b want 0", busy); end
        rst = 1'b0;
        req = 1'b0;
        $display("[TB] reset in hold at cycle %0d", rel);
        tick();
    endtask

    // The scoreboard schedules captures from the timing rules: the first at W+D, then every D cycles.
    // After each handshake the next capture is D cycles later. Words are never captured while one is pending.
    task automatic test_random();
        int          next_cap;
        int          cnt;
        int          run;
        int          words;
        logic [31:0] acc;
        logic [31:0] m_word;
        logic [7:0]  last;
        bit          m_valid;
        bit          m_fail;
        bit          done;
        mode = 2;
        start_req();
        next_cap = W + D; cnt = 0; run = 0; words = 0;
        acc = '0; m_word = '0; last = '0; m_valid = 0; m_fail = 0; done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            wif.word_ready = ($urandom_range(0, 2) != 0);
            n_tests++; if (wif.word_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid cycle %0d got %b want %b", rel, wif.word_valid, m_valid); end
            n_tests++; if (health_fail !== m_fail) begin n_fail++; $display("FAIL rnd_hfail cycle %0d got %b want %b", rel, health_fail, m_fail); end
            n_tests++; if (rng_enable !== (!m_fail && rel >= 1)) begin n_fail++; $display("FAIL rnd_enable cycle %0d got %b want %b", rel, rng_enable, (!m_fail && rel >= 1)); end
            if (m_valid) begin
                n_tests++; if (wif.word_out !== m_word) begin n_fail++; $display("FAIL rnd_word cycle %0d got %h want %h", rel, wif.word_out, m_word); end
            end
            if (m_fail) begin
                done = 1;
            end else if (m_valid) begin
                if (wif.word_ready) begin
                    words++;
                    $display("[TB] random word %0d: %h accepted at cycle %0d", words, m_word, rel);
                    m_valid  = 0;
                    next_cap = rel + D;
                end
            end else if (rel == next_cap) begin
                acc  = {acc[23:0], rng_data};
                run  = (rng_data == last) ? run + 1 : 1;
                last = rng_data;
                cnt++;
                if (run == RL) begin
                    m_fail = 1;
                end else if (cnt == WB) begin
                    m_valid = 1;
                    m_word  = acc;
                    cnt     = 0;
                end else begin
                    next_cap += D;
                end
            end
            if (!done) tick();
        end
        wif.word_ready = 1'b0;
        req = 1'b0;
        if (done) begin
            $display("[TB] random stream: health trip at cycle %0d after %0d words", rel, words);
            clr_fail = 1'b1;
            tick();
            clr_fail = 1'b0;
            n_tests++; if (health_fail !== 1'b0) begin n_fail++; $display("FAIL rnd_clr got %b want 0", health_fail); end
        end
        mode = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_req_low_hold();
        test_stuck();
        test_abort();
        test_reset_in_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
